video_in_capture: RTL and testbench
===================================

VIDEO_IN_CAPTURE -- requirements
Module: video_in_capture

Interface
REQ-001 The block SHALL have parameter CROP_H_BIAS, default 11'd256, meaning the first captured pixel column, counted from 0 at DE rise.
REQ-002 The block SHALL have parameter CROP_H_WIDTH, default 11'd512, meaning the captured columns per line.
REQ-003 The block SHALL have parameter CROP_V_BIAS, default 11'd144, meaning the first captured active line, counted from 0 after VSYNC rise.
REQ-004 The block SHALL have parameter CROP_V_WIDTH, default 11'd480, meaning the captured lines per frame.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- VIN_PCLK in 1: pixel clock, the only clock.
- RESET in 1: asynchronous, active-high reset.
- VIN_HSYNC in 1: horizontal sync, active-high.
- VIN_VSYNC in 1: vertical sync, active-high.
- VIN_DE in 1: data enable, high during active pixels.
- VIN_DATA in 16: RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
- ENABLE in 1: capture request, sampled at frame boundary.
- CAP_DATA out 16: captured pixel.
- CAP_VALID out 1: CAP_DATA/CAP_ADDR qualifier.
- CAP_ADDR out 18: linear pixel index within the captured frame.
- CAP_FRAME_START out 1: one-cycle pulse when a captured frame begins.
- CAP_FRAME_DONE out 1: one-cycle pulse when a captured frame completes without error.
- MEAS_HACTIVE out 11: measured DE-high pixels per line.
- MEAS_VACTIVE out 11: measured DE lines per frame.
- LOCKED out 1: stable format detected.
- FORMAT_ERR out 1: one-cycle pulse on format violation.

Function
REQ-006 The block SHALL register VIN_HSYNC, VIN_VSYNC, VIN_DE, VIN_DATA and ENABLE once on VIN_PCLK before any use, and SHALL use VIN_HSYNC for no decision.
REQ-007 The block SHALL treat a registered VSYNC 0->1 transition as the frame boundary (FB), and registered DE 0->1 and 1->0 transitions as line start and line end.
REQ-008 The column counter x (11-bit) SHALL be 0 on the first DE-high pixel of a line and SHALL increment per DE-high pixel, saturating at 2047.
REQ-009 The line counter y (11-bit) SHALL clear at FB and SHALL increment at each line end, saturating at 2047.
REQ-010 At each line end the block SHALL record the line length (x+1); at FB the frame's first line length and its final y SHALL be the frame measurement.
REQ-011 The state machine SHALL have three states: SEARCH (reset state), MEASURE and LOCK.
REQ-012 SEARCH SHALL go to MEASURE at the next FB.
REQ-013 MEASURE SHALL go to LOCK at the next FB when all lines had equal nonzero length and y is nonzero, loading MEAS_HACTIVE/MEAS_VACTIVE at that FB; otherwise it SHALL go to SEARCH and pulse FORMAT_ERR.
REQ-014 In LOCK, any line end whose length is not MEAS_HACTIVE SHALL set a sticky frame_bad flag.
REQ-015 In LOCK, a frame that sets frame_bad, or whose y is not MEAS_VACTIVE at FB, SHALL cause the following at that FB: FORMAT_ERR pulses, state goes to SEARCH, and CAP_FRAME_DONE is suppressed.
REQ-016 LOCKED SHALL equal (state == LOCK).
REQ-017 A frame SHALL be captured only if the state is LOCK at its opening FB and registered ENABLE is 1 at that FB; changes to ENABLE mid-frame SHALL be ignored.
REQ-018 At the opening FB of a captured frame, CAP_FRAME_START SHALL pulse for one cycle and the address counter SHALL clear to 0.
REQ-019 In a captured frame, a pixel SHALL be valid iff DE=1, CROP_H_BIAS <= x < CROP_H_BIAS+CROP_H_WIDTH, and CROP_V_BIAS <= y < CROP_V_BIAS+CROP_V_WIDTH.
REQ-020 Valid-pixel latency SHALL be fixed: VIN_DATA sampled at VIN_PCLK edge k SHALL appear on CAP_DATA with CAP_VALID=1 after edge k+2.
REQ-021 CAP_ADDR SHALL equal the number of valid pixels emitted earlier in the same frame; this also holds when the crop window exceeds the active area (fewer pixels, no gaps).
REQ-022 CAP_VALID SHALL be 0 outside valid pixels; CAP_DATA and CAP_ADDR SHALL hold their last values when CAP_VALID is 0.
REQ-023 At the FB closing a captured frame without error, CAP_FRAME_DONE SHALL pulse for one cycle. When that FB also opens a new captured frame, CAP_FRAME_DONE and CAP_FRAME_START SHALL pulse in the same cycle.

Reset
REQ-024 RESET SHALL asynchronously force state=SEARCH; all counters to 0; all outputs to 0; and frame_bad and edge-detect history to 0.
REQ-025 A RESET mid-frame SHALL abort the frame with no CAP_FRAME_DONE; lock SHALL be reacquired by the REQ-012/REQ-013 sequence.

Verification
REQ-026 Reset check: assert RESET with inputs toggling -> all outputs 0 and LOCKED=0 while RESET is high.
REQ-027 Lock and capture: CROP_H_BIAS=2, CROP_H_WIDTH=4, CROP_V_BIAS=1, CROP_V_WIDTH=2, and 8x4 active frames with VIN_DATA=16*y+x.
- LOCKED rises at the 2nd FB after reset, with MEAS_HACTIVE=8 and MEAS_VACTIVE=4.
- ENABLE=1, next frame: CAP_DATA sequence 0x12,0x13,0x14,0x15,0x22,0x23,0x24,0x25 at CAP_ADDR 0..7.
- Each pixel appears 2 cycles after its input.
- CAP_FRAME_DONE pulses at the following FB.
REQ-028 Format break: in a locked frame, line 2 has 7 pixels -> at next FB, FORMAT_ERR=1 for one cycle, LOCKED=0, no CAP_FRAME_DONE.
REQ-029 ENABLE gating: ENABLE=0 at FB, raised mid-frame -> zero CAP_VALID that frame; capture starts at the next FB.
REQ-030 Oversized window: CROP_H_BIAS=6, CROP_H_WIDTH=4 on 8-wide lines -> 2 pixels per cropped line, CAP_ADDR contiguous 0..3, CAP_FRAME_DONE still pulses.
REQ-031 Mid-frame reset: RESET during captured line 1 -> CAP_VALID stops immediately, no CAP_FRAME_DONE, LOCKED reasserts two FBs after release.

Source files
------------

// File: rtl/video_in_capture.sv
// Video input capture: measures the incoming DE/VSYNC geometry, locks onto a stable
// format and emits a cropped RGB565 window with linear addresses at fixed latency.
module video_in_capture #(
  parameter logic [10:0] CROP_H_BIAS  = 11'd256,
  parameter logic [10:0] CROP_H_WIDTH = 11'd512,
  parameter logic [10:0] CROP_V_BIAS  = 11'd144,
  parameter logic [10:0] CROP_V_WIDTH = 11'd480
) (
  input  logic        VIN_PCLK,
  input  logic        RESET,
  input  logic        VIN_HSYNC,
  input  logic        VIN_VSYNC,
  input  logic        VIN_DE,
  input  logic [15:0] VIN_DATA,
  input  logic        ENABLE,
  output logic [15:0] CAP_DATA,
  output logic        CAP_VALID,
  output logic [17:0] CAP_ADDR,
  output logic        CAP_FRAME_START,
  output logic        CAP_FRAME_DONE,
  output logic [10:0] MEAS_HACTIVE,
  output logic [10:0] MEAS_VACTIVE,
  output logic        LOCKED,
  output logic        FORMAT_ERR
);

  localparam int DATA_W = 16;
  localparam logic [11:0] H_END = {1'b0, CROP_H_BIAS} + {1'b0, CROP_H_WIDTH};
  localparam logic [11:0] V_END = {1'b0, CROP_V_BIAS} + {1'b0, CROP_V_WIDTH};

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCK = 2'd2} state_t;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  logic              hs_unused_p1_q;
  logic              vs_p1_q, de_p1_q, en_p1_q;
  logic [DATA_W-1:0] data_p1_q;
  logic              vs_p2_q, de_p2_q;
  logic [DATA_W-1:0] data_p2_q;

  state_t            state_q, state_d;
  logic [10:0]       x_q, x_d, y_q, y_d;
  logic [10:0]       first_len_q, first_len_d;
  logic [10:0]       meas_h_q, meas_h_d, meas_v_q, meas_v_d;
  logic              frame_bad_q, frame_bad_d;
  logic              cap_active_q, cap_active_d;
  logic [17:0]       addr_q, addr_d;
  logic              cap_valid_q, cap_valid_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic [17:0]       cap_addr_q, cap_addr_d;
  logic              start_q, start_d, done_q, done_d, err_q, err_d;

  logic              vs_rise, de_rise, de_fall, in_win;
  logic [10:0]       line_len;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    first_len_d  = first_len_q;
    meas_h_d     = meas_h_q;
    meas_v_d     = meas_v_q;
    frame_bad_d  = frame_bad_q;
    cap_active_d = cap_active_q;
    addr_d       = addr_q;
    cap_valid_d  = 1'b0;
    cap_data_d   = cap_data_q;
    cap_addr_d   = cap_addr_q;
    start_d      = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    vs_rise  = vs_p1_q & ~vs_p2_q;
    de_rise  = de_p1_q & ~de_p2_q;
    de_fall  = ~de_p1_q & de_p2_q;
    line_len = sat_inc11(x_q);

    // stage p1 -> p2: column of the pixel now moving into p2
    if (de_p1_q) begin
      x_d = de_rise ? 11'd0 : sat_inc11(x_q);
    end

    // stage p2 -> output: x_q/y_q describe the pixel held in data_p2_q
    in_win = de_p2_q && cap_active_q &&
             (x_q >= CROP_H_BIAS) && ({1'b0, x_q} < H_END) &&
             (y_q >= CROP_V_BIAS) && ({1'b0, y_q} < V_END);
    if (in_win) begin
      cap_valid_d = 1'b1;
      cap_data_d  = data_p2_q;
      cap_addr_d  = addr_q;
      addr_d      = addr_q + 18'd1;
    end

    if (de_fall) begin
      y_d = sat_inc11(y_q);
      if (y_q == 11'd0) begin
        first_len_d = line_len;
      end
      if (state_q == LOCK && line_len != meas_h_q) begin
        frame_bad_d = 1'b1;
      end
      if (state_q == MEASURE && y_q != 11'd0 && line_len != first_len_q) begin
        frame_bad_d = 1'b1;
      end
    end

    if (vs_rise) begin
      y_d          = 11'd0;
      frame_bad_d  = 1'b0;
      first_len_d  = 11'd0;
      cap_active_d = 1'b0;
      case (state_q)
        SEARCH: state_d = MEASURE;
        MEASURE: begin
          if (!frame_bad_q && y_q != 11'd0 && first_len_q != 11'd0) begin
            state_d  = LOCK;
            meas_h_d = first_len_q;
            meas_v_d = y_q;
          end else begin
            state_d = SEARCH;
            err_d   = 1'b1;
          end
        end
        LOCK: begin
          if (frame_bad_q || y_q != meas_v_q) begin
            state_d = SEARCH;
            err_d   = 1'b1;
          end else begin
            done_d = cap_active_q;
            if (en_p1_q) begin
              cap_active_d = 1'b1;
              start_d      = 1'b1;
              addr_d       = 18'd0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge VIN_PCLK or posedge RESET) begin
    if (RESET) begin
      hs_unused_p1_q <= 1'b0;
      vs_p1_q        <= 1'b0;
      de_p1_q        <= 1'b0;
      en_p1_q        <= 1'b0;
      data_p1_q      <= '0;
      vs_p2_q        <= 1'b0;
      de_p2_q        <= 1'b0;
      data_p2_q      <= '0;
      state_q        <= SEARCH;
      x_q            <= '0;
      y_q            <= '0;
      first_len_q    <= '0;
      meas_h_q       <= '0;
      meas_v_q       <= '0;
      frame_bad_q    <= 1'b0;
      cap_active_q   <= 1'b0;
      addr_q         <= '0;
      cap_valid_q    <= 1'b0;
      cap_data_q     <= '0;
      cap_addr_q     <= '0;
      start_q        <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      hs_unused_p1_q <= VIN_HSYNC;
      vs_p1_q        <= VIN_VSYNC;
      de_p1_q        <= VIN_DE;
      en_p1_q        <= ENABLE;
      data_p1_q      <= VIN_DATA;
      vs_p2_q        <= vs_p1_q;
      de_p2_q        <= de_p1_q;
      data_p2_q      <= data_p1_q;
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      first_len_q    <= first_len_d;
      meas_h_q       <= meas_h_d;
      meas_v_q       <= meas_v_d;
      frame_bad_q    <= frame_bad_d;
      cap_active_q   <= cap_active_d;
      addr_q         <= addr_d;
      cap_valid_q    <= cap_valid_d;
      cap_data_q     <= cap_data_d;
      cap_addr_q     <= cap_addr_d;
      start_q        <= start_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign CAP_DATA        = cap_data_q;
  assign CAP_VALID       = cap_valid_q;
  assign CAP_ADDR        = cap_addr_q;
  assign CAP_FRAME_START = start_q;
  assign CAP_FRAME_DONE  = done_q;
  assign MEAS_HACTIVE    = meas_h_q;
  assign MEAS_VACTIVE    = meas_v_q;
  assign LOCKED          = (state_q == LOCK);
  assign FORMAT_ERR      = err_q;

endmodule

// File: tb/tb_video_in_capture.sv
// Directed bench for video_in_capture: two instances with different horizontal crops
// share one 8x4 video stream (VIN_DATA = 16*y + x).
module tb_video_in_capture;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, de, en;
  logic [15:0] din;

  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid, a_start, b_start, a_done, b_done;
  logic [17:0] a_addr, b_addr;
  logic [10:0] a_mh, a_mv, b_mh, b_mv;
  logic        a_locked, b_locked, a_err, b_err;

  video_in_capture #(.CROP_H_BIAS(11'd2), .CROP_H_WIDTH(11'd4),
                     .CROP_V_BIAS(11'd1), .CROP_V_WIDTH(11'd2)) dut_a (
    .VIN_PCLK(clk), .RESET(rst), .VIN_HSYNC(hsync), .VIN_VSYNC(vsync), .VIN_DE(de),
    .VIN_DATA(din), .ENABLE(en), .CAP_DATA(a_data), .CAP_VALID(a_valid),
    .CAP_ADDR(a_addr), .CAP_FRAME_START(a_start), .CAP_FRAME_DONE(a_done),
    .MEAS_HACTIVE(a_mh), .MEAS_VACTIVE(a_mv), .LOCKED(a_locked), .FORMAT_ERR(a_err));

  video_in_capture #(.CROP_H_BIAS(11'd6), .CROP_H_WIDTH(11'd4),
                     .CROP_V_BIAS(11'd1), .CROP_V_WIDTH(11'd2)) dut_b (
    .VIN_PCLK(clk), .RESET(rst), .VIN_HSYNC(hsync), .VIN_VSYNC(vsync), .VIN_DE(de),
    .VIN_DATA(din), .ENABLE(en), .CAP_DATA(b_data), .CAP_VALID(b_valid),
    .CAP_ADDR(b_addr), .CAP_FRAME_START(b_start), .CAP_FRAME_DONE(b_done),
    .MEAS_HACTIVE(b_mh), .MEAS_VACTIVE(b_mv), .LOCKED(b_locked), .FORMAT_ERR(b_err));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int drv_cyc [0:3][0:7];

  logic [15:0] qa_data[$], qb_data[$];
  int          qa_addr[$], qb_addr[$], qa_cyc[$];
  int          start_a, done_a, err_a, done_b, start_cyc_a, done_cyc_a;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (a_valid) begin
      qa_data.push_back(a_data);
      qa_addr.push_back(int'(a_addr));
      qa_cyc.push_back(cyc);
    end
    if (b_valid) begin
      qb_data.push_back(b_data);
      qb_addr.push_back(int'(b_addr));
    end
    if (a_start) begin start_a++; start_cyc_a = cyc; end
    if (a_done)  begin done_a++;  done_cyc_a  = cyc; end
    if (a_err)   err_a++;
    if (b_done)  done_b++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic clear_mon();
    qa_data.delete(); qa_addr.delete(); qa_cyc.delete();
    qb_data.delete(); qb_addr.delete();
    start_a = 0; done_a = 0; err_a = 0; done_b = 0;
    start_cyc_a = -1; done_cyc_a = -2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      de = 1'b0; din = 16'h0; hsync = 1'b0;
    end
  endtask

  task automatic do_fb();
    @(negedge clk); vsync = 1'b1; de = 1'b0;
    @(negedge clk);
    @(negedge clk); vsync = 1'b0;
    idle(3);
  endtask

  // Four lines; line bad_y gets bad_len pixels; ENABLE set to en_val before line en_y.
  task automatic do_lines(input int bad_y, input int bad_len, input int en_y,
                          input logic en_val);
    idle(2);
    for (int y = 0; y < 4; y++) begin
      if (y == en_y) en = en_val;
      for (int x = 0; x < ((y == bad_y) ? bad_len : 8); x++) begin
        @(negedge clk);
        de = 1'b1; din = 16'(16 * y + x); drv_cyc[y][x] = cyc;
      end
      @(negedge clk); de = 1'b0; din = 16'h0; hsync = 1'b1;
      @(negedge clk); hsync = 1'b0;
      idle(2);
    end
    idle(3);
  endtask

  task automatic test_reset();
    logic [60:0] obs;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hsync = 1'($urandom); vsync = 1'($urandom); de = 1'($urandom);
      din = 16'($urandom); en = 1'($urandom);
      #1;
      obs = {a_data, a_valid, a_addr, a_start, a_done, a_mh, a_mv, a_locked, a_err};
      n_vec++;
      if (obs !== 61'd0) begin
        n_err++;
        $display("FAIL reset_outputs: got %h, required 0", obs);
      end
    end
    @(negedge clk);
    hsync = 1'b0; vsync = 1'b0; de = 1'b0; din = 16'h0; en = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_lock();
    clear_mon();
    do_fb();
    n_vec++;
    if (a_locked !== 1'b0) begin n_err++; $display("FAIL lock_fb1: LOCKED=%b, required 0", a_locked); end
    do_lines(-1, 8, -1, 1'b0);
    do_fb();
    n_vec++;
    if (a_locked !== 1'b1) begin n_err++; $display("FAIL lock_fb2: LOCKED=%b, required 1", a_locked); end
    n_vec++;
    if (a_mh !== 11'd8 || a_mv !== 11'd4) begin
      n_err++; $display("FAIL lock_meas: H=%0d V=%0d, required H=8 V=4", a_mh, a_mv);
    end
    n_vec++;
    if (err_a !== 0) begin n_err++; $display("FAIL lock_no_err: FORMAT_ERR pulses=%0d, required 0", err_a); end
    do_lines(-1, 8, -1, 1'b0);
  endtask

  task automatic test_capture();
    logic [15:0] exp_d;
    int          ey, ex;
    en = 1'b1;
    clear_mon();
    do_fb();
    n_vec++;
    if (start_a !== 1 || done_a !== 0) begin
      n_err++; $display("FAIL cap_open: start=%0d done=%0d, required 1 0", start_a, done_a);
    end
    clear_mon();
    do_lines(-1, 8, -1, 1'b1);
    n_vec++;
    if (qa_data.size() !== 8) begin
      n_err++; $display("FAIL cap_count: pixels=%0d, required 8", qa_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        ey = 1 + i / 4; ex = 2 + i % 4; exp_d = 16'(16 * ey + ex);
        n_vec++;
        if (qa_data[i] !== exp_d || qa_addr[i] !== i || qa_cyc[i] !== drv_cyc[ey][ex] + 3) begin
          n_err++;
          $display("FAIL cap_pixel%0d: data=%h addr=%0d cyc=%0d, required data=%h addr=%0d cyc=%0d",
                   i, qa_data[i], qa_addr[i], qa_cyc[i], exp_d, i, drv_cyc[ey][ex] + 3);
        end
      end
    end
    n_vec++;
    if (qb_data.size() !== 4) begin
      n_err++; $display("FAIL oversize_count: pixels=%0d, required 4", qb_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 16'(16 * (1 + i / 2) + 6 + i % 2);
        n_vec++;
        if (qb_data[i] !== exp_d || qb_addr[i] !== i) begin
          n_err++;
          $display("FAIL oversize_pixel%0d: data=%h addr=%0d, required data=%h addr=%0d",
                   i, qb_data[i], qb_addr[i], exp_d, i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    do_fb();
    n_vec++;
    if (done_a !== 1 || start_a !== 1) begin
      n_err++; $display("FAIL b2b_pulses: done=%0d start=%0d, required 1 1", done_a, start_a);
    end
    n_vec++;
    if (done_cyc_a !== start_cyc_a) begin
      n_err++; $display("FAIL b2b_same_cycle: done@%0d start@%0d, required equal", done_cyc_a, start_cyc_a);
    end
    n_vec++;
    if (done_b !== 1) begin n_err++; $display("FAIL oversize_done: pulses=%0d, required 1", done_b); end
    clear_mon();
    do_lines(-1, 8, 2, 1'b0);
    n_vec++;
    if (qa_data.size() !== 8) begin
      n_err++; $display("FAIL en_drop_ignored: pixels=%0d, required 8", qa_data.size());
    end
  endtask

  task automatic test_enable_gating();
    clear_mon();
    do_fb();
    n_vec++;
    if (done_a !== 1 || start_a !== 0) begin
      n_err++; $display("FAIL gate_fb: done=%0d start=%0d, required 1 0", done_a, start_a);
    end
    clear_mon();
    do_lines(-1, 8, 1, 1'b1);
    n_vec++;
    if (qa_data.size() !== 0 || qb_data.size() !== 0) begin
      n_err++; $display("FAIL gate_no_valid: a=%0d b=%0d pixels, required 0 0", qa_data.size(), qb_data.size());
    end
    clear_mon();
    do_fb();
    n_vec++;
    if (start_a !== 1 || done_a !== 0) begin
      n_err++; $display("FAIL gate_next_fb: start=%0d done=%0d, required 1 0", start_a, done_a);
    end
  endtask

  task automatic test_format_break();
    clear_mon();
    do_lines(2, 7, -1, 1'b1);
    n_vec++;
    if (qa_data.size() !== 8 || qa_data[0] !== 16'h0012) begin
      n_err++; $display("FAIL brk_capture: pixels=%0d, required 8 starting 0012", qa_data.size());
    end
    clear_mon();
    do_fb();
    n_vec++;
    if (err_a !== 1) begin n_err++; $display("FAIL brk_err: FORMAT_ERR cycles=%0d, required 1", err_a); end
    n_vec++;
    if (a_locked !== 1'b0 || done_a !== 0) begin
      n_err++; $display("FAIL brk_state: LOCKED=%b done=%0d, required 0 0", a_locked, done_a);
    end
  endtask

  task automatic test_mid_frame_reset();
    do_fb();
    do_lines(-1, 8, -1, 1'b1);
    do_fb();
    n_vec++;
    if (a_locked !== 1'b1) begin n_err++; $display("FAIL relock: LOCKED=%b, required 1", a_locked); end
    do_lines(-1, 8, -1, 1'b1);
    clear_mon();
    do_fb();
    n_vec++;
    if (start_a !== 1) begin n_err++; $display("FAIL rst_open: start=%0d, required 1", start_a); end
    idle(2);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        @(negedge clk);
        de = 1'b1; din = 16'(16 * y + x);
        if (y == 1 && x == 5) begin
          #2;
          n_vec++;
          if (a_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: CAP_VALID=%b, required 1", a_valid); end
          rst = 1'b1;
          #1;
          n_vec++;
          if (a_valid !== 1'b0 || a_locked !== 1'b0 || a_addr !== 18'd0 || a_mh !== 11'd0) begin
            n_err++;
            $display("FAIL rst_immediate: valid=%b locked=%b addr=%0d mh=%0d, required all 0",
                     a_valid, a_locked, a_addr, a_mh);
          end
          clear_mon();
        end
      end
      @(negedge clk); de = 1'b0; din = 16'h0; rst = 1'b0;
      idle(3);
    end
    idle(3);
    n_vec++;
    if (qa_data.size() !== 0) begin
      n_err++; $display("FAIL rst_no_valid: pixels=%0d, required 0", qa_data.size());
    end
    do_fb();
    n_vec++;
    if (done_a !== 0 || a_locked !== 1'b0) begin
      n_err++; $display("FAIL rst_fb1: done=%0d LOCKED=%b, required 0 0", done_a, a_locked);
    end
    do_lines(-1, 8, -1, 1'b1);
    do_fb();
    n_vec++;
    if (a_locked !== 1'b1 || a_mh !== 11'd8 || a_mv !== 11'd4 || done_a !== 0) begin
      n_err++;
      $display("FAIL rst_fb2: LOCKED=%b H=%0d V=%0d done=%0d, required 1 8 4 0",
               a_locked, a_mh, a_mv, done_a);
    end
  endtask

  initial begin
    rst = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b0; din = 16'h0; en = 1'b0;
    clear_mon();
    test_reset();
    test_lock();
    test_capture();
    test_back_to_back();
    test_enable_gating();
    test_format_break();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
